// File: rtl/gl_bram_arbiter.sv
// gl_bram_arbiter: shares one BRAM read port between single-word fetch reads and
// multi-word decode operand bursts, tagging each returned word with its requester.
module gl_bram_arbiter #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 5,
    parameter int ADDR_STEP = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_f_req,
    input  logic [WIDTH-1:0]     i_f_addr,
    output logic                 o_f_valid,
    output logic [WIDTH-1:0]     o_f_data,
    output logic                 o_fetch_stall,
    input  logic                 i_d_req,
    input  logic [WIDTH-1:0]     i_d_addr,
    input  logic [LEN_WIDTH-1:0] i_d_len,
    output logic                 o_d_busy,
    output logic                 o_d_valid,
    output logic                 o_d_last,
    output logic [WIDTH-1:0]     o_d_data,
    output logic                 o_bram_en,
    output logic [WIDTH-1:0]     o_bram_addr,
    input  logic [WIDTH-1:0]     i_bram_dout
);
    typedef enum logic [1:0] {IDLE, FETCH, BURST, DRAIN} state_t;

    state_t               r_state, w_next;
    logic                 r_en, r_src, r_busy, r_fair;
    logic                 r_f_valid, r_d_valid, r_d_last;
    logic [WIDTH-1:0]     r_addr;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 w_elig, w_issue_f, w_issue_d, w_burst_end;

    // a burst is only eligible once any owed fairness fetch has been served
    assign w_elig      = i_d_req & (i_d_len != '0) & ~r_fair;
    assign w_burst_end = (r_state == BURST) && (r_cnt == '0);

    always_comb begin
        w_next    = r_state;
        w_issue_f = 1'b0;
        w_issue_d = 1'b0;
        case (r_state)
            IDLE, FETCH: begin
                if (w_elig) begin
                    w_next    = BURST;
                    w_issue_d = 1'b1;
                end else if (i_f_req) begin
                    w_next    = FETCH;
                    w_issue_f = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            BURST:   w_next = w_burst_end ? DRAIN : BURST;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_src     <= 1'b0;
            r_busy    <= 1'b0;
            r_fair    <= 1'b0;
            r_f_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_last  <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_f_valid <= r_en & ~r_src;
            r_d_valid <= r_en & r_src;
            r_d_last  <= w_burst_end;
            if (w_issue_d) begin
                r_addr <= i_d_addr;
                r_en   <= 1'b1;
                r_src  <= 1'b1;
                r_cnt  <= i_d_len - 1'b1;
                r_busy <= 1'b1;
            end else if (w_issue_f) begin
                r_addr <= i_f_addr;
                r_en   <= 1'b1;
                r_src  <= 1'b0;
                r_fair <= 1'b0;
            end else if (r_state == BURST) begin
                if (r_cnt != '0) begin
                    r_addr <= r_addr + WIDTH'(ADDR_STEP);
                    r_cnt  <= r_cnt - 1'b1;
                end else begin
                    r_en <= 1'b0;
                end
            end else if (r_state == DRAIN) begin
                r_en   <= 1'b0;
                r_busy <= 1'b0;
                r_fair <= i_f_req;
            end else begin
                r_en   <= 1'b0;
                r_fair <= 1'b0;
            end
        end
    end

    assign o_fetch_stall = i_f_req & ~w_issue_f;
    assign o_f_valid     = r_f_valid;
    assign o_d_valid     = r_d_valid;
    assign o_d_last      = r_d_last;
    assign o_d_busy      = r_busy;
    assign o_bram_en     = r_en;
    assign o_bram_addr   = r_addr;
    assign o_f_data      = i_bram_dout;
    assign o_d_data      = i_bram_dout;
endmodule
